sipo_route_rx: RTL and testbench
================================

Name: sipo_route_rx

Overview:
- Receive-side deserializer for the column route-data serial link.
- Accepts the 1-bit route stream plus its frame-start strobe from a column serializer, and rebuilds 28-bit route words MSB first.
- Buffers completed words in a small FIFO for the periphery readout logic, which drains them with a read-enable handshake.
- Reports framing errors and overflow through sticky flags.

Parameters:
- DATA_W, 28, serial word width in bits.
- FIFO_DEPTH, 4, word FIFO depth; must be a power of two, at least 2.
- CNT_W, 3, FIFO occupancy width; equals log2(FIFO_DEPTH)+1.

Ports:
- clk_40MHz  input  1  link clock, same clock as the serializer.
- rst_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  route data bit, MSB first.
- valid_in  input  1  frame start; high for exactly the cycle that carries bit DATA_W-1.
- rd_en  input  1  pop request from readout; ignored when FIFO is empty.
- clr_flags  input  1  clears frame_err and overflow.
- rd_data  output  DATA_W  FIFO head word; valid while rd_valid is high.
- rd_valid  output  1  FIFO not empty.
- fifo_count  output  CNT_W  number of stored words.
- rx_busy  output  1  high while a frame is mid-reception (state SHIFT).
- frame_err  output  1  sticky; set when valid_in arrives mid-frame.
- overflow  output  1  sticky; set when a word completes while the FIFO is full.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk_40MHz.
- Reset values:
  - state IDLE, bit counter 0, shift register 0.
  - FIFO pointers 0, so rd_valid=0 and fifo_count=0.
  - rd_data=0, rx_busy=0, frame_err=0, overflow=0.
- Reset mid-frame discards the partial word and all FIFO contents.
- Serial framing:
  - The cycle with valid_in=1 carries bit DATA_W-1.
  - The following DATA_W-1 cycles carry bits DATA_W-2 down to 0, one bit per cycle, with no gaps.
  - Frames may be back to back: the next valid_in may occur in the cycle right after bit 0.
- State machine, two states:
  - IDLE, valid_in=1: capture serial_in as the MSB, bit counter := 1, go to SHIFT. Otherwise stay in IDLE; serial_in is ignored.
  - SHIFT, valid_in=0: shift serial_in into the LSB and increment the bit counter.
  - SHIFT, counter = DATA_W-1: this bit is bit 0. The word {shreg[DATA_W-2:0], serial_in} completes at this edge; go to IDLE.
  - SHIFT, valid_in=1 before bit 0: discard the partial word and set frame_err. Restart the frame with this bit as the MSB (counter := 1, stay in SHIFT). No word is written.
- rx_busy = (state == SHIFT).
- Latency:
  - valid_in sampled in cycle C0; bit 0 arrives in cycle C0+DATA_W-1.
  - The word is written to the FIFO at the end of that cycle.
  - rd_valid rises in C0+DATA_W if the FIFO was empty, i.e. cycle C28 for DATA_W=28.
- FIFO:
  - First-word-fall-through: rd_data shows the head word whenever rd_valid=1.
  - rd_en with rd_valid=1 pops at the clock edge.
  - Pointers wrap modulo FIFO_DEPTH.
  - Write when full (fifo_count == FIFO_DEPTH) and no pop in the same cycle: drop the word, set overflow, leave contents unchanged.
  - Write and pop in the same cycle while full: both succeed and fifo_count stays the same.
  - Write and pop in the same cycle while empty: the new word is stored and fifo_count becomes 1. No fall-through bypass within a cycle.
  - rd_en while empty: no effect, no error.
- All-zero words are stored like any other word; no filtering.
- Sticky flags:
  - clr_flags clears frame_err and overflow on the next edge.
  - A set condition in the same cycle as clr_flags wins: the flag stays 1.

Optional Feature:
- Macro: SIPO_RX_STATS_EN.
- Defined:
  - Adds output frame_cnt[15:0]: increments on every word completion, including dropped words, and wraps 0xFFFF to 0.
  - Adds output err_cnt[7:0]: increments on each frame_err or overflow event and saturates at 0xFF.
  - Both counters reset to 0 and clear together with clr_flags; an event coinciding with clr_flags leaves the counter at 1.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Single frame 0xA5C3E71, rd_en=0: rx_busy high for cycles C1..C27; rd_valid rises at C28, rd_data=0xA5C3E71, fifo_count=1, no flags set.
- Back-to-back frames 0x0000001 then 0x8000000 (second valid_in one cycle after the first frame's bit 0): both words stored in order, fifo_count=2, frame_err=0.
- valid_in re-asserted at bit index 10 of a frame, followed by a full frame 0x1234567: only 0x1234567 stored, frame_err=1; clr_flags then drops frame_err to 0.
- Five frames with rd_en=0 (FIFO_DEPTH=4): first four stored, fifth dropped, overflow=1, fifo_count=4. Repeat with rd_en=1 during the fifth word's completion cycle: all five words recovered, overflow=0.
- rst_n pulsed low at bit index 15 of a frame, then a fresh frame 0x7FFFFFF: outputs at reset values during reset; only 0x7FFFFFF appears afterwards.
- With SIPO_RX_STATS_EN defined, 3 good frames plus 1 mid-frame abort: frame_cnt=3, err_cnt=1; after clr_flags both read 0.

Source files
------------

// File: rtl/sipo_route_rx.sv
// sipo_route_rx: 1-bit route stream deserializer with FWFT word FIFO and sticky flags; define SIPO_RX_STATS_EN for frame/error counters
module sipo_route_rx #(
  parameter int DATA_W     = 28,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk_40MHz,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              valid_in,
  input  logic              rd_en,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overflow
`ifdef SIPO_RX_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
`endif
);
  localparam int CW = $clog2(DATA_W);
  localparam int AW = CNT_W - 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_N = CNT_W'(FIFO_DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-2:0]   shreg_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic                frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic                word_done, err_ev, ovf_ev, full, pop, push;
  logic [DATA_W-1:0]   word;
  assign word       = {shreg_q, serial_in};
  assign word_done  = state_q == SHIFT && !valid_in && cnt_q == LAST;
  assign err_ev     = state_q == SHIFT && valid_in;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign full       = fifo_count == FULL_N;
  assign rd_valid   = fifo_count != '0;
  assign pop        = rd_en && rd_valid;
  assign push       = word_done && (!full || pop);
  assign ovf_ev     = word_done && full && !pop;
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign rx_busy    = state_q == SHIFT;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign frame_err_d = err_ev | (frame_err_q & ~clr_flags);
  assign overflow_d  = ovf_ev | (overflow_q & ~clr_flags);
  // frame FSM: valid_in always (re)starts a frame with this bit as MSB, otherwise shift until bit 0
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (valid_in) begin
      state_q <= SHIFT;
      cnt_q   <= CW'(1);
      shreg_q <= (DATA_W-1)'(serial_in);
    end else if (state_q == SHIFT) begin
      shreg_q <= word[DATA_W-2:0];
      cnt_q   <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
      state_q <= cnt_q == LAST ? IDLE : SHIFT;
    end
  end
  // FIFO pointers; extra MSB distinguishes full from empty
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + CNT_W'(push);
      rd_ptr_q <= rd_ptr_q + CNT_W'(pop);
    end
  end
  // word storage; contents are don't-care until a pointer covers them
  always_ff @(posedge clk_40MHz) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word;
  end
  // sticky flags; a set event outranks the clear
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end
`ifdef SIPO_RX_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        any_err;
  assign any_err   = err_ev | ovf_ev;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  // completed-word counter (wrapping, dropped words included) and saturating error counter
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= clr_flags ? 16'(word_done) : frame_cnt_q + 16'(word_done);
      err_cnt_q   <= clr_flags ? 8'(any_err) : err_cnt_q + 8'(any_err && err_cnt_q != 8'hFF);
    end
  end
`endif
endmodule

// File: tb/tb_sipo_route_rx.sv
// tb_sipo_route_rx: directed self-checking bench for sipo_route_rx
module tb_sipo_route_rx;
  logic        clk_40MHz = 0, rst_n = 0, serial_in = 0, valid_in = 0, rd_en = 0, clr_flags = 0;
  logic [27:0] rd_data;
  logic        rd_valid, rx_busy, frame_err, overflow;
  logic [2:0]  fifo_count;
`ifdef SIPO_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif
  int   checks = 0, errors = 0;
  logic busy_bad = 0;
  always #5 clk_40MHz = ~clk_40MHz;
  sipo_route_rx dut (
    .clk_40MHz(clk_40MHz), .rst_n(rst_n), .serial_in(serial_in), .valid_in(valid_in),
    .rd_en(rd_en), .clr_flags(clr_flags), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .rx_busy(rx_busy), .frame_err(frame_err), .overflow(overflow)
`ifdef SIPO_RX_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [27:0] w, input int n);
    for (int i = 27; i > 27 - n; i--) begin
      @(negedge clk_40MHz);
      if (i != 27 && rx_busy !== 1'b1) busy_bad = 1;
      valid_in  = (i == 27);
      serial_in = w[i];
    end
  endtask
  task automatic idle();
    @(negedge clk_40MHz);
    valid_in  = 0;
    serial_in = 0;
    rd_en     = 0;
    clr_flags = 0;
  endtask
  task automatic pop_chk(input string tag, input logic [27:0] exp);
    chk(tag, rd_data, exp);
    rd_en = 1;
    @(negedge clk_40MHz);
    rd_en = 0;
  endtask
  task automatic clear();
    clr_flags = 1;
    @(negedge clk_40MHz);
    clr_flags = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    @(negedge clk_40MHz);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1;
    send(28'hA5C3E71, 27);
    @(negedge clk_40MHz);
    chk("t1_valid_c27", rd_valid, 0);
    chk("t1_busy_c27", rx_busy, 1);
    valid_in  = 0;
    serial_in = 1;
    idle();
    chk("t1_valid_c28", rd_valid, 1);
    chk("t1_data", rd_data, 28'hA5C3E71);
    chk("t1_count", fifo_count, 1);
    chk("t1_busy_c28", rx_busy, 0);
    chk("t1_frame_err", frame_err, 0);
    chk("t1_overflow", overflow, 0);
    chk("t1_busy_window", busy_bad, 0);
    pop_chk("t1_pop", 28'hA5C3E71);
    chk("t1_count_after", fifo_count, 0);
    rd_en = 1;
    @(negedge clk_40MHz);
    rd_en = 0;
    chk("empty_pop_count", fifo_count, 0);
    chk("empty_pop_valid", rd_valid, 0);
    chk("empty_pop_ovf", overflow, 0);
    send(28'h0000001, 28);
    send(28'h8000000, 28);
    idle();
    chk("t2_count", fifo_count, 2);
    chk("t2_frame_err", frame_err, 0);
    pop_chk("t2_w0", 28'h0000001);
    pop_chk("t2_w1", 28'h8000000);
    chk("t2_count_after", fifo_count, 0);
    send(28'hFFFFFFF, 17);
    send(28'h1234567, 28);
    idle();
    chk("t3_count", fifo_count, 1);
    chk("t3_frame_err", frame_err, 1);
    pop_chk("t3_word", 28'h1234567);
    chk("t3_count_after", fifo_count, 0);
    clear();
    chk("t3_frame_err_clr", frame_err, 0);
    send(28'h1111111, 28);
    send(28'h2222222, 28);
    send(28'h3333333, 28);
    send(28'h4444444, 28);
    send(28'h5555555, 27);
    @(negedge clk_40MHz);
    valid_in  = 0;
    serial_in = 1;
    clr_flags = 1;
    idle();
    chk("t4_overflow_set_wins", overflow, 1);
    chk("t4_count", fifo_count, 4);
    pop_chk("t4_w0", 28'h1111111);
    pop_chk("t4_w1", 28'h2222222);
    pop_chk("t4_w2", 28'h3333333);
    pop_chk("t4_w3", 28'h4444444);
    chk("t4_count_after", fifo_count, 0);
    clear();
    chk("t4_overflow_clr", overflow, 0);
    send(28'h1111111, 28);
    send(28'h2222222, 28);
    send(28'h3333333, 28);
    send(28'h4444444, 28);
    send(28'h5555555, 27);
    @(negedge clk_40MHz);
    chk("t4b_w0", rd_data, 28'h1111111);
    valid_in  = 0;
    serial_in = 1;
    rd_en     = 1;
    idle();
    chk("t4b_count", fifo_count, 4);
    chk("t4b_overflow", overflow, 0);
    pop_chk("t4b_w1", 28'h2222222);
    pop_chk("t4b_w2", 28'h3333333);
    pop_chk("t4b_w3", 28'h4444444);
    pop_chk("t4b_w4", 28'h5555555);
    chk("t4b_count_after", fifo_count, 0);
    send(28'h0ABCDEF, 28);
    idle();
    chk("t5_pre_count", fifo_count, 1);
    send(28'h5A5A5A5, 12);
    @(negedge clk_40MHz);
    rst_n     = 0;
    valid_in  = 0;
    serial_in = 0;
    #1;
    chk("t5_rst_valid", rd_valid, 0);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_busy", rx_busy, 0);
    chk("t5_rst_data", rd_data, 0);
    @(negedge clk_40MHz);
    rst_n = 1;
    send(28'h7FFFFFF, 28);
    idle();
    chk("t5_count", fifo_count, 1);
    chk("t5_busy", rx_busy, 0);
    pop_chk("t5_word", 28'h7FFFFFF);
    chk("t5_count_after", fifo_count, 0);
`ifdef SIPO_RX_STATS_EN
    clear();
    chk("st_frame_cnt0", frame_cnt, 0);
    chk("st_err_cnt0", err_cnt, 0);
    send(28'hFFFFFFF, 10);
    send(28'h0000001, 28);
    send(28'h0000002, 28);
    send(28'h0000003, 28);
    idle();
    chk("st_frame_cnt", frame_cnt, 3);
    chk("st_err_cnt", err_cnt, 1);
    chk("st_count", fifo_count, 3);
    pop_chk("st_w0", 28'h0000001);
    pop_chk("st_w1", 28'h0000002);
    pop_chk("st_w2", 28'h0000003);
    clear();
    chk("st_frame_cnt_clr", frame_cnt, 0);
    chk("st_err_cnt_clr", err_cnt, 0);
`endif
    chk("busy_window_all", busy_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
